rw_toags_window: RTL and testbench



---
 rtl/rw_toags_pkg.sv | 29 ++
 rtl/rw_window_acc.sv | 51 +++++
 rtl/rw_toags_window.sv | 87 ++++++++
 tb/tb_rw_toags_window.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rw_toags_pkg.sv
// Shared types and helpers for the toggle/AND window machine.
package rw_toags_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2,
        HALT = 2'd3
    } tag_t;

    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;

    // Widest stream the seed helper can describe; callers truncate to W.
    localparam int SEED_MAX_W = 256;

    // Identity element of the reduction: all ones for AND, zeros for OR.
    function automatic logic [SEED_MAX_W-1:0] seed(input int w, input int op);
        logic [SEED_MAX_W-1:0] s;
        s = '0;
        if (op == OP_AND) begin
            for (int i = 0; i < SEED_MAX_W; i++) begin
                if (i < w) s[i] = 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/rw_window_acc.sv
// Window accumulator: folds LEN samples with AND/OR and flags the last one.
module rw_window_acc
    import rw_toags_pkg::*;
#(
    parameter int W   = 1,
    parameter int LEN = 2,
    parameter int OP  = OP_AND
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic         last,
    output logic [W-1:0] acc
);

    localparam int           CW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [W-1:0] SEED = W'(seed(W, OP));

    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CW'(LEN - 1));
    assign acc  = acc_q;

    // Clear has priority; otherwise fold one sample and advance the count.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = SEED;
            cnt_d = '0;
        end else if (en) begin
            acc_d = (OP == OP_OR) ? (acc_q | data) : (acc_q & data);
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    // Accumulator and sample counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= SEED;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rw_toags_window.sv
// Windowed AND/OR reduction with a per-window toggling pass-through mask
// and a sticky stop request.
module rw_toags_window
    import rw_toags_pkg::*;
#(
    parameter int           W         = 1,
    parameter int           LEN       = 2,
    parameter int           OP        = OP_AND,
    parameter logic [W-1:0] MASK_INIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] __in0,
    input  logic         __in1,
    output logic [W-1:0] __out0,
    output logic         __continue
);

    tag_t         tag_q, tag_d;
    logic [W-1:0] st1_q, st1_d;
    logic         stop;
    logic         acc_clr, acc_en, acc_last;
    logic [W-1:0] acc_val;

    rw_window_acc #(.W(W), .LEN(LEN), .OP(OP)) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .data (__in0),
        .last (acc_last),
        .acc  (acc_val)
    );

    // Next-state and Mealy outputs; a stop overrides the state's actions.
    // Reset masks stop so outputs show IDLE values while rst is held.
    always_comb begin
        stop       = __in1 && (tag_q != HALT) && !rst;
        tag_d      = tag_q;
        st1_d      = st1_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        __out0     = '0;
        __continue = 1'b1;
        case (tag_q)
            IDLE: begin
                tag_d   = ACC;
                acc_clr = 1'b1;
            end
            ACC: begin
                __out0 = __in0 & st1_q;
                acc_en = 1'b1;
                if (acc_last) tag_d = EMIT;
            end
            EMIT: begin
                __out0  = acc_val;
                st1_d   = ~st1_q;
                acc_clr = 1'b1;
                tag_d   = ACC;
            end
            HALT: begin
                __continue = 1'b0;
            end
            default: tag_d = IDLE;
        endcase
        if (stop) begin
            tag_d      = HALT;
            st1_d      = st1_q;
            acc_clr    = 1'b0;
            acc_en     = 1'b0;
            __out0     = '0;
            __continue = 1'b0;
        end
    end

    // State tag and toggle mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= IDLE;
            st1_q <= MASK_INIT;
        end else begin
            tag_q <= tag_d;
            st1_q <= st1_d;
        end
    end

endmodule

// File: tb/tb_rw_toags_window.sv
// Directed bench: three configurations run in lockstep from a vector table,
// then hand sequences for stop, async reset and stop+reset on the AND unit.
module tb_rw_toags_window;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a_in0 = '0, b_in0 = '0;
    logic       c_in0 = 1'b0;
    logic       a_in1 = 1'b0, b_in1 = 1'b0, c_in1 = 1'b0;
    logic [3:0] a_out, b_out;
    logic       c_out;
    logic       a_cont, b_cont, c_cont;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rw_toags_window #(.W(4), .LEN(3), .OP(0), .MASK_INIT(4'hF)) dut_a (
        .clk(clk), .rst(rst), .__in0(a_in0), .__in1(a_in1),
        .__out0(a_out), .__continue(a_cont));
    rw_toags_window #(.W(4), .LEN(3), .OP(1), .MASK_INIT(4'hF)) dut_b (
        .clk(clk), .rst(rst), .__in0(b_in0), .__in1(b_in1),
        .__out0(b_out), .__continue(b_cont));
    rw_toags_window #(.W(1), .LEN(1), .OP(0), .MASK_INIT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .__in0(c_in0), .__in1(c_in1),
        .__out0(c_out), .__continue(c_cont));

    typedef struct {
        logic [3:0] ain;
        logic [3:0] aout;
        logic [3:0] bin;
        logic [3:0] bout;
        logic       cin;
        logic       cout;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset all units for one edge and release one time unit after it.
    task automatic do_reset();
        rst = 1'b1;
        a_in0 = '0; a_in1 = 1'b0;
        b_in0 = '0; b_in1 = 1'b0;
        c_in0 = 1'b0; c_in1 = 1'b0;
        tick();
        chk("rst_out", a_out, 4'h0);
        chk("rst_cont", {3'b0, a_cont}, 4'h1);
        rst = 1'b0;
    endtask

    // One cycle on unit A: drive, sample at negedge, advance past posedge.
    task automatic va(input string name, input logic [3:0] in0, input logic in1,
                      input logic [3:0] eout, input logic econt);
        a_in0 = in0;
        a_in1 = in1;
        @(negedge clk);
        chk({name, "_out"}, a_out, eout);
        chk({name, "_cont"}, {3'b0, a_cont}, {3'b0, econt});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ain aout bin bout cin cout
        tbl[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}; // IDLE
        tbl[1] = '{4'hF, 4'hF, 4'h1, 4'h1, 1'b1, 1'b1}; // ACC / C ACC
        tbl[2] = '{4'hE, 4'hE, 4'h2, 4'h2, 1'b0, 1'b1}; // ACC / C EMIT
        tbl[3] = '{4'h7, 4'h7, 4'h8, 4'h8, 1'b1, 1'b0}; // ACC / C ACC mask 0
        tbl[4] = '{4'h3, 4'h6, 4'h3, 4'hB, 1'b0, 1'b1}; // EMIT
        tbl[5] = '{4'hF, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0}; // ACC mask 0 / C ACC
        tbl[6] = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}; // ACC / C EMIT 0
        tbl[7] = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0}; // ACC / C ACC mask 0
        tbl[8] = '{4'h0, 4'hF, 4'h0, 4'h4, 1'b0, 1'b1}; // EMIT
        tbl[9] = '{4'h5, 4'h5, 4'h6, 4'h6, 1'b1, 1'b1}; // ACC mask restored

        do_reset();
        for (int i = 0; i < 10; i++) begin
            a_in0 = tbl[i].ain;
            b_in0 = tbl[i].bin;
            c_in0 = tbl[i].cin;
            @(negedge clk);
            chk($sformatf("vec%0d_a", i), a_out, tbl[i].aout);
            chk($sformatf("vec%0d_b", i), b_out, tbl[i].bout);
            chk($sformatf("vec%0d_c", i), {3'b0, c_out}, {3'b0, tbl[i].cout});
            chk($sformatf("vec%0d_conta", i), {3'b0, a_cont}, 4'h1);
            chk($sformatf("vec%0d_contb", i), {3'b0, b_cont}, 4'h1);
            chk($sformatf("vec%0d_contc", i), {3'b0, c_cont}, 4'h1);
            tick();
        end

        // Stop on the second ACC cycle, then HALT ignores all inputs.
        do_reset();
        va("s_idle", 4'h0, 1'b0, 4'h0, 1'b1);
        va("s_acc1", 4'hF, 1'b0, 4'hF, 1'b1);
        va("s_stop", 4'hF, 1'b1, 4'h0, 1'b0);
        va("s_halt1", 4'hF, 1'b0, 4'h0, 1'b0);
        va("s_halt2", 4'hA, 1'b1, 4'h0, 1'b0);
        va("s_halt3", 4'h5, 1'b0, 4'h0, 1'b0);

        // Async reset mid-ACC drops the partial window.
        do_reset();
        va("r_idle", 4'h0, 1'b0, 4'h0, 1'b1);
        va("r_acc0", 4'h0, 1'b0, 4'h0, 1'b1);
        a_in0 = 4'hF;
        @(negedge clk);
        chk("r_pre_out", a_out, 4'hF);
        #1 rst = 1'b1;
        #1;
        chk("r_async_out", a_out, 4'h0);
        chk("r_async_cont", {3'b0, a_cont}, 4'h1);
        tick();
        rst = 1'b0;
        va("r2_idle", 4'hF, 1'b0, 4'h0, 1'b1);
        va("r2_acc1", 4'hF, 1'b0, 4'hF, 1'b1);
        va("r2_acc2", 4'hF, 1'b0, 4'hF, 1'b1);
        va("r2_acc3", 4'hF, 1'b0, 4'hF, 1'b1);
        va("r2_emit", 4'h0, 1'b0, 4'hF, 1'b1);
        a_in0 = 4'hF;
        @(negedge clk);
        chk("r2_masked", a_out, 4'h0);
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
        va("r3_idle", 4'hF, 1'b0, 4'h0, 1'b1);
        va("r3_mask_init", 4'hF, 1'b0, 4'hF, 1'b1);

        // Stop in EMIT suppresses the result; then stop with reset.
        do_reset();
        va("e_idle", 4'h0, 1'b0, 4'h0, 1'b1);
        va("e_acc1", 4'h3, 1'b0, 4'h3, 1'b1);
        va("e_acc2", 4'h3, 1'b0, 4'h3, 1'b1);
        va("e_acc3", 4'h3, 1'b0, 4'h3, 1'b1);
        va("e_stop", 4'h0, 1'b1, 4'h0, 1'b0);
        va("e_halt", 4'hF, 1'b0, 4'h0, 1'b0);
        a_in1 = 1'b1;
        rst   = 1'b1;
        #1;
        chk("sr_out", a_out, 4'h0);
        chk("sr_cont", {3'b0, a_cont}, 4'h1);
        tick();
        rst   = 1'b0;
        a_in1 = 1'b0;
        va("sr_idle", 4'hF, 1'b0, 4'h0, 1'b1);
        va("sr_acc1", 4'hF, 1'b0, 4'hF, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
